credit_scroll_ctrl: RTL and testbench



---
 rtl/credit_scroll_ctrl_if.sv | 21 ++
 rtl/credit_scroll_ctrl.sv | 117 +++++++++++
 tb/tb_credit_scroll_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/credit_scroll_ctrl_if.sv
// rtl/credit_scroll_ctrl_if.sv - frame/game-state inputs and credit overlay outputs
interface credit_scroll_ctrl_if;
  logic        startOfFrame;
  logic        gameEnded;
  logic        restartReq;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        creditVisible;
  logic        creditDone;
  logic        busy;

  modport master (
    output startOfFrame, gameEnded, restartReq,
    input  topLeftX, topLeftY, creditVisible, creditDone, busy
  );

  modport slave (
    input  startOfFrame, gameEnded, restartReq,
    output topLeftX, topLeftY, creditVisible, creditDone, busy
  );
endinterface

// File: rtl/credit_scroll_ctrl.sv
// rtl/credit_scroll_ctrl.sv - end-of-game credit overlay sequencer
// Waits, scrolls the credit square up to its rest line, holds, then flags done.
module credit_scroll_ctrl #(
  parameter int X_POS           = 288,
  parameter int START_Y         = 480,
  parameter int END_Y           = 380,
  parameter int DELAY_FRAMES    = 60,
  parameter int FRAMES_PER_STEP = 2,
  parameter int STEP_PIXELS     = 1,
  parameter int HOLD_FRAMES     = 180
) (
  input  logic                 clk,
  input  logic                 resetN,
  credit_scroll_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DELAY, SCROLL, HOLD, DONE} state_t;

  localparam logic [10:0] X_V     = 11'(X_POS);
  localparam logic [10:0] START_V = 11'(START_Y);
  localparam logic [10:0] END_V   = 11'(END_Y);
  localparam logic [15:0] DF      = 16'(DELAY_FRAMES);
  localparam logic [15:0] FPS     = 16'(FRAMES_PER_STEP);
  localparam logic [15:0] HF      = 16'(HOLD_FRAMES);

  state_t             state, state_nx;
  logic [15:0]        cnt, cnt_nx, cnt_inc;
  logic [10:0]        y_q, y_nx, y_step;
  logic signed [11:0] y_sub;
  logic               vis_q, vis_nx, done_q, done_nx, busy_q, busy_nx;

  assign cnt_inc = cnt + 16'd1;

  // Signed intermediate so a large step below END_Y clamps instead of wrapping.
  assign y_sub  = $signed({1'b0, y_q}) - $signed(12'(STEP_PIXELS));
  assign y_step = (y_sub < $signed({1'b0, END_V})) ? END_V : y_sub[10:0];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    y_nx     = y_q;
    case (state)
      IDLE: begin
        y_nx = START_V;
        if (bus.gameEnded) state_nx = DELAY;
      end
      DELAY: begin
        if (DF == 16'd0) state_nx = SCROLL;
        else if (bus.startOfFrame) begin
          if (cnt_inc == DF) state_nx = SCROLL;
          else cnt_nx = cnt_inc;
        end
      end
      SCROLL: begin
        if (bus.startOfFrame) begin
          if (cnt_inc == FPS) begin
            cnt_nx = '0;
            y_nx   = y_step;
            if (y_step == END_V) state_nx = HOLD;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      HOLD: begin
        y_nx = END_V;
        if (HF == 16'd0) state_nx = DONE;
        else if (bus.startOfFrame) begin
          if (cnt_inc == HF) state_nx = DONE;
          else cnt_nx = cnt_inc;
        end
      end
      DONE: begin
        if (bus.restartReq) begin
          state_nx = IDLE;
          y_nx     = START_V;
        end
      end
      default: begin
        state_nx = IDLE;
        y_nx     = START_V;
      end
    endcase

    // Counter restarts on every state entry, so an entry-cycle frame pulse is lost.
    if (state_nx != state) cnt_nx = '0;

    vis_nx  = state_nx inside {SCROLL, HOLD, DONE};
    done_nx = (state_nx == DONE);
    busy_nx = state_nx inside {DELAY, SCROLL, HOLD};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      cnt    <= '0;
      y_q    <= START_V;
      vis_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      y_q    <= y_nx;
      vis_q  <= vis_nx;
      done_q <= done_nx;
      busy_q <= busy_nx;
    end
  end

  assign bus.topLeftX      = X_V;
  assign bus.topLeftY      = y_q;
  assign bus.creditVisible = vis_q;
  assign bus.creditDone    = done_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_credit_scroll_ctrl.sv
// tb/tb_credit_scroll_ctrl.sv - directed scoreboard bench for credit_scroll_ctrl
module tb_credit_scroll_ctrl;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  credit_scroll_ctrl_if ia ();
  credit_scroll_ctrl_if ib ();
  credit_scroll_ctrl_if ic ();

  credit_scroll_ctrl dut_a (.clk(clk), .resetN(rst_a), .bus(ia));

  credit_scroll_ctrl #(
    .START_Y(400), .END_Y(390), .DELAY_FRAMES(2),
    .FRAMES_PER_STEP(1), .STEP_PIXELS(4), .HOLD_FRAMES(3)
  ) dut_b (.clk(clk), .resetN(rst_b), .bus(ib));

  credit_scroll_ctrl #(
    .START_Y(380), .END_Y(380), .DELAY_FRAMES(0),
    .FRAMES_PER_STEP(1), .STEP_PIXELS(1), .HOLD_FRAMES(2)
  ) dut_c (.clk(clk), .resetN(rst_c), .bus(ic));

  typedef struct {
    string       tag;
    logic [10:0] y;
    logic        vis;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic drive(input int which, input logic sof, input logic rr, input logic ge);
    case (which)
      0: begin ia.startOfFrame = sof; ia.restartReq = rr; ia.gameEnded = ge; end
      1: begin ib.startOfFrame = sof; ib.restartReq = rr; ib.gameEnded = ge; end
      default: begin ic.startOfFrame = sof; ic.restartReq = rr; ic.gameEnded = ge; end
    endcase
  endtask

  task automatic cmp(input int which);
    exp_t        e;
    logic [10:0] y;
    logic        v, d, b;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    case (which)
      0: begin y = ia.topLeftY; v = ia.creditVisible; d = ia.creditDone; b = ia.busy; end
      1: begin y = ib.topLeftY; v = ib.creditVisible; d = ib.creditDone; b = ib.busy; end
      default: begin y = ic.topLeftY; v = ic.creditVisible; d = ic.creditDone; b = ic.busy; end
    endcase
    check({e.tag, ".y"},    32'(y), 32'(e.y));
    check({e.tag, ".vis"},  32'(v), 32'(e.vis));
    check({e.tag, ".done"}, 32'(d), 32'(e.done));
    check({e.tag, ".busy"}, 32'(b), 32'(e.busy));
  endtask

  task automatic step(input int which, input logic sof, input logic rr, input logic ge,
                      input string tag, input int y, input logic v, input logic d, input logic b);
    exp_t e;
    drive(which, sof, rr, ge);
    e.tag = tag; e.y = 11'(y); e.vis = v; e.done = d; e.busy = b;
    sb.push_back(e);
    cyc();
    drive(which, 1'b0, 1'b0, ge);
    cmp(which);
  endtask

  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      drive(which, 1'b1, 1'b0, 1'b0);
      cyc();
      drive(which, 1'b0, 1'b0, 1'b0);
      cyc();
    end
  endtask

  initial begin
    exp_t e;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(2, 0, 0, 0);
    repeat (3) cyc();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // default-parameter instance: run into SCROLL, frame gating, async reset
    step(0, 0, 0, 0, "a_rst", 480, 0, 0, 0);
    check("a_x", 32'(ia.topLeftX), 32'd288);
    step(0, 0, 0, 1, "a_go", 480, 0, 0, 1);
    pulse(0, 59);
    step(0, 0, 0, 0, "a_delay59", 480, 0, 0, 1);
    step(0, 1, 0, 0, "a_scroll", 480, 1, 0, 1);
    step(0, 0, 0, 0, "a_gap", 480, 1, 0, 1);
    for (int i = 0; i < 200 && ia.topLeftY !== 11'd431; i++) pulse(0, 1);
    check("a_reach431", 32'(ia.topLeftY), 32'd431);
    step(0, 1, 0, 0, "a_half", 431, 1, 0, 1);
    repeat (1000) cyc();
    step(0, 0, 0, 0, "a_frozen", 431, 1, 0, 1);
    step(0, 1, 0, 0, "a_430", 430, 1, 0, 1);
    #2 rst_a = 1'b0;
    #1;
    e.tag = "a_async_rst"; e.y = 11'd480; e.vis = 1'b0; e.done = 1'b0; e.busy = 1'b0;
    sb.push_back(e);
    cmp(0);
    check("a_x_rst", 32'(ia.topLeftX), 32'd288);
    cyc();
    rst_a = 1'b1;

    // nominal run with clamped last step, ignored restarts, restart with gameEnded held
    step(1, 0, 0, 0, "b_rst", 400, 0, 0, 0);
    step(1, 0, 0, 1, "b_go", 400, 0, 0, 1);
    step(1, 1, 0, 0, "b_f1", 400, 0, 0, 1);
    step(1, 0, 0, 0, "b_gap", 400, 0, 0, 1);
    step(1, 1, 0, 0, "b_f2", 400, 1, 0, 1);
    step(1, 1, 0, 0, "b_s396", 396, 1, 0, 1);
    step(1, 0, 1, 0, "b_rr_scroll", 396, 1, 0, 1);
    step(1, 1, 0, 0, "b_s392", 392, 1, 0, 1);
    step(1, 1, 0, 0, "b_s390", 390, 1, 0, 1);
    step(1, 0, 1, 0, "b_rr_hold", 390, 1, 0, 1);
    step(1, 1, 0, 0, "b_h1", 390, 1, 0, 1);
    step(1, 1, 0, 0, "b_h2", 390, 1, 0, 1);
    step(1, 1, 0, 0, "b_done", 390, 1, 1, 0);
    step(1, 1, 0, 0, "b_done_stay", 390, 1, 1, 0);
    step(1, 1, 1, 1, "b_restart", 400, 0, 0, 0);
    step(1, 0, 0, 1, "b_reenter", 400, 0, 0, 1);
    drive(1, 0, 0, 0);
    pulse(1, 8);
    step(1, 0, 0, 0, "b_abort_immune", 390, 1, 1, 0);

    // degenerate START_Y == END_Y with zero delay
    step(2, 0, 0, 0, "c_rst", 380, 0, 0, 0);
    step(2, 0, 0, 1, "c_go", 380, 0, 0, 1);
    step(2, 0, 0, 1, "c_delay0", 380, 1, 0, 1);
    step(2, 0, 0, 0, "c_wait", 380, 1, 0, 1);
    step(2, 1, 0, 0, "c_hold", 380, 1, 0, 1);
    step(2, 1, 0, 0, "c_h1", 380, 1, 0, 1);
    step(2, 1, 0, 0, "c_done", 380, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
